// File: rtl/conv_layer_sequencer.sv
// Sequences one convolutional_layer pass: weights, bias, then idle-gated pixels from a 1-cycle-latency RAM.
// Packets appear one cycle after their read; conv_idle=0 holds the next pixel read. CONV_SEQ_PERF_EN adds stall_cycles.
module conv_layer_sequencer #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 18,
    parameter int NUM_WEIGHTS = 9,
    parameter int NUM_BIAS    = 9
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH-1:0] num_pixels,
    output logic                  mem_rd_en,
    output logic [ADDR_WIDTH-1:0] mem_rd_addr,
    input  logic [DATA_WIDTH-1:0] mem_rd_data,
    output logic [DATA_WIDTH-1:0] conv_packet,
    output logic                  weights_valid,
    output logic                  bias_valid,
    output logic                  input_valid,
    input  logic                  conv_idle,
    input  logic                  conv_out_valid,
    input  logic                  conv_done,
    output logic                  busy,
    output logic                  done,
`ifdef CONV_SEQ_PERF_EN
    output logic [31:0]           out_count,
    output logic [31:0]           stall_cycles
`else
    output logic [31:0]           out_count
`endif
);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD_W, S_LOAD_B, S_STREAM, S_DRAIN, S_DONE
    } state_t;

    typedef enum logic [1:0] {K_NONE, K_W, K_B, K_P} kind_t;

    localparam logic [7:0] LAST_W = 8'(NUM_WEIGHTS - 1);
    localparam logic [7:0] LAST_B = 8'(NUM_BIAS - 1);

    state_t                r_state;
    state_t                w_state_nxt;
    kind_t                 r_rd_kind;
    kind_t                 w_rd_kind;
    logic                  w_rd_en;
    logic                  w_pend;
    logic                  w_stall;
    logic                  w_any_vld;
    logic                  w_start_ok;
    logic [7:0]            r_cnt;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [ADDR_WIDTH-1:0] r_pix_left;
    logic [DATA_WIDTH-1:0] r_hold;
    logic [31:0]           r_out_count;
    logic [31:0]           r_stall;

    // r_rd_kind records what the previous cycle's read was; its data is on mem_rd_data now.
    assign w_pend     = (r_rd_kind == K_P);
    assign w_any_vld  = (r_rd_kind != K_NONE);
    assign w_start_ok = (r_state == S_IDLE) && start;

    always_comb begin
        w_state_nxt = r_state;
        w_rd_en     = 1'b0;
        w_rd_kind   = K_NONE;
        w_stall     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) w_state_nxt = S_LOAD_W;
            end
            S_LOAD_W: begin
                w_rd_en   = 1'b1;
                w_rd_kind = K_W;
                if (r_cnt == LAST_W) w_state_nxt = S_LOAD_B;
            end
            S_LOAD_B: begin
                w_rd_en   = 1'b1;
                w_rd_kind = K_B;
                if (r_cnt == LAST_B)
                    w_state_nxt = (r_pix_left == '0) ? S_DRAIN : S_STREAM;
            end
            S_STREAM: begin
                // One pixel in flight at a time: no read in the cycle its data is driven.
                if (!w_pend) begin
                    if (conv_idle) begin
                        w_rd_en   = 1'b1;
                        w_rd_kind = K_P;
                        if (r_pix_left == ADDR_WIDTH'(1)) w_state_nxt = S_DRAIN;
                    end else begin
                        w_stall = 1'b1;
                    end
                end
            end
            S_DRAIN: begin
                if (conv_done) w_state_nxt = S_DONE;
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_rd_kind   <= K_NONE;
            r_cnt       <= '0;
            r_addr      <= '0;
            r_pix_left  <= '0;
            r_hold      <= '0;
            r_out_count <= '0;
            r_stall     <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_rd_kind <= w_rd_kind;
            if (w_any_vld) r_hold <= mem_rd_data;

            if (w_start_ok) begin
                r_addr     <= base_addr;
                r_pix_left <= num_pixels;
                r_cnt      <= '0;
            end else begin
                if (w_rd_en) r_addr <= r_addr + ADDR_WIDTH'(1);
                if (w_rd_kind == K_W || w_rd_kind == K_B)
                    r_cnt <= (w_state_nxt != r_state) ? 8'd0 : r_cnt + 8'd1;
                if (w_rd_kind == K_P) r_pix_left <= r_pix_left - ADDR_WIDTH'(1);
            end

            if (w_start_ok)
                r_out_count <= '0;
            else if (r_state != S_IDLE && conv_out_valid && r_out_count != '1)
                r_out_count <= r_out_count + 32'd1;

            if (w_start_ok)
                r_stall <= '0;
            else if (w_stall && r_stall != '1)
                r_stall <= r_stall + 32'd1;
        end
    end

    assign mem_rd_en     = w_rd_en;
    assign mem_rd_addr   = r_addr;
    assign conv_packet   = w_any_vld ? mem_rd_data : r_hold;
    assign weights_valid = (r_rd_kind == K_W);
    assign bias_valid    = (r_rd_kind == K_B);
    assign input_valid   = (r_rd_kind == K_P);
    assign busy          = (r_state != S_IDLE);
    assign done          = (r_state == S_DONE);
    assign out_count     = r_out_count;

`ifdef CONV_SEQ_PERF_EN
    assign stall_cycles = r_stall;
`else
    logic w_unused_stall;
    assign w_unused_stall = ^r_stall;
`endif

endmodule

// File: tb/tb_conv_layer_sequencer.sv
// Scoreboard bench for conv_layer_sequencer: RAM model plus expected-packet queue checked at every strobe.
module tb_conv_layer_sequencer;

    logic        clock;
    logic        reset;
    logic        start;
    logic [17:0] base_addr;
    logic [17:0] num_pixels;
    logic        mem_rd_en;
    logic [17:0] mem_rd_addr;
    logic [31:0] mem_rd_data;
    logic [31:0] conv_packet;
    logic        weights_valid;
    logic        bias_valid;
    logic        input_valid;
    logic        conv_idle;
    logic        conv_out_valid;
    logic        conv_done;
    logic        busy;
    logic        done;
    logic [31:0] out_count;
`ifdef CONV_SEQ_PERF_EN
    logic [31:0] stall_cycles;
`endif

    int          n_checks = 0;
    int          n_errs   = 0;
    int          n_done   = 0;
    bit          done_ok  = 0;
    bit          stall_win = 0;
    bit          prev_iv  = 0;
    bit          prev_done = 0;
    logic [33:0] sb[$];
    logic [33:0] mon_exp;
    logic [1:0]  mon_kind;

    conv_layer_sequencer #(
        .DATA_WIDTH(32), .ADDR_WIDTH(18), .NUM_WEIGHTS(9), .NUM_BIAS(9)
    ) dut (
        .clock(clock), .reset(reset), .start(start),
        .base_addr(base_addr), .num_pixels(num_pixels),
        .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
        .conv_packet(conv_packet), .weights_valid(weights_valid),
        .bias_valid(bias_valid), .input_valid(input_valid),
        .conv_idle(conv_idle), .conv_out_valid(conv_out_valid), .conv_done(conv_done),
        .busy(busy), .done(done),
`ifdef CONV_SEQ_PERF_EN
        .out_count(out_count), .stall_cycles(stall_cycles)
`else
        .out_count(out_count)
`endif
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    function automatic logic [31:0] memf(input logic [17:0] a);
        return {a[9:0], 4'h5, a} ^ 32'h3C96_0000;
    endfunction

    always @(posedge clock) begin
        if (mem_rd_en) mem_rd_data <= memf(mem_rd_addr);
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    initial begin
        forever begin
            @(negedge clock);
            mon_kind = weights_valid ? 2'd1 : bias_valid ? 2'd2 : input_valid ? 2'd3 : 2'd0;
            if (weights_valid || bias_valid || input_valid) begin
                chk("one_strobe", 64'(int'(weights_valid) + int'(bias_valid) + int'(input_valid)), 64'd1);
                chk("sb_nonempty", 64'(sb.size() != 0), 64'd1);
                if (sb.size() != 0) begin
                    mon_exp = sb.pop_front();
                    chk("pkt", {30'b0, mon_kind, conv_packet}, {30'b0, mon_exp});
                end
            end
            if (input_valid) chk("iv_gap", 64'(prev_iv), 64'd0);
            prev_iv = input_valid;
            if (stall_win) chk("rd_in_stall", 64'(mem_rd_en), 64'd0);
            if (done) begin
                n_done++;
                chk("done_allowed", 64'(done_ok), 64'd1);
                chk("done_1cyc", 64'(prev_done), 64'd0);
            end
            prev_done = done;
        end
    end

    task automatic push_pass(input logic [17:0] base, input int n);
        for (int i = 0; i < 9; i++) sb.push_back({2'd1, memf(base + 18'(i))});
        for (int i = 0; i < 9; i++) sb.push_back({2'd2, memf(base + 18'(9 + i))});
        for (int i = 0; i < n; i++) sb.push_back({2'd3, memf(base + 18'(18 + i))});
    endtask

    task automatic run_pass(input logic [17:0] base, input int n, input int n_out,
                            input bit do_stall, input bit do_edges);
        int cyc;
        int beats;
        bit stalled;
        push_pass(base, n);
        n_done  = 0;
        beats   = n_out;
        stalled = 0;
        base_addr  = base;
        num_pixels = 18'(n);
        start = 1'b1;
        step(1);
        start = 1'b0;
        base_addr  = '0;
        num_pixels = '0;
        cyc = 0;
        while (sb.size() != 0 && cyc < 4000) begin
            conv_out_valid = (beats > 0);
            if (beats > 0) beats--;
            conv_done = do_edges && (cyc == 2);
            if (do_edges && cyc == 3) begin
                start      = 1'b1;
                base_addr  = 18'h02000;
                num_pixels = 18'd7;
            end else begin
                start = 1'b0;
            end
            if (do_stall && !stalled && input_valid && sb.size() >= 4) begin
                stalled = 1;
                step(1);
                conv_out_valid = 1'b0;
                conv_idle = 1'b0;
                stall_win = 1;
                step(5);
                conv_idle = 1'b1;
                stall_win = 0;
            end
            step(1);
            cyc++;
        end
        chk("sb_drained", 64'(sb.size()), 64'd0);
        conv_done = 1'b0;
        start     = 1'b0;
        base_addr  = '0;
        num_pixels = '0;
        while (beats > 0) begin
            conv_out_valid = 1'b1;
            beats--;
            step(1);
        end
        conv_out_valid = 1'b0;
        step(2);
        done_ok   = 1;
        conv_done = 1'b1;
        step(1);
        conv_done = 1'b0;
        cyc = 0;
        while (n_done == 0 && cyc < 10) begin
            step(1);
            cyc++;
        end
        done_ok = 0;
        chk("done_count", 64'(n_done), 64'd1);
        chk("out_count", 64'(out_count), 64'(n_out));
        chk("busy_after", 64'(busy), 64'd0);
`ifdef CONV_SEQ_PERF_EN
        if (do_stall) chk("stall_cycles", 64'(stall_cycles), 64'd5);
`endif
        step(3);
        chk("out_count_hold", 64'(out_count), 64'(n_out));
        sb.delete();
    endtask

    initial begin
        int cyc;
        reset = 1'b1;
        start = 1'b1;
        base_addr  = 18'h00040;
        num_pixels = 18'd3;
        conv_idle = 1'b1;
        conv_out_valid = 1'b0;
        conv_done = 1'b0;
        step(2);
        chk("rst_rd_en", 64'(mem_rd_en), 64'd0);
        chk("rst_rd_addr", 64'(mem_rd_addr), 64'd0);
        chk("rst_packet", 64'(conv_packet), 64'd0);
        chk("rst_wv", 64'(weights_valid), 64'd0);
        chk("rst_bv", 64'(bias_valid), 64'd0);
        chk("rst_iv", 64'(input_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_out_count", 64'(out_count), 64'd0);
        reset = 1'b0;
        start = 1'b0;
        base_addr  = '0;
        num_pixels = '0;
        step(1);
        chk("idle_after_rst", 64'(busy), 64'd0);

        run_pass(18'h00100, 4, 3, 1'b0, 1'b1);
        run_pass(18'h3FFF0, 12, 6, 1'b1, 1'b0);
        run_pass(18'h00200, 0, 2, 1'b0, 1'b0);
        run_pass(18'h01000, 300, 300, 1'b0, 1'b0);

        push_pass(18'h00500, 20);
        base_addr  = 18'h00500;
        num_pixels = 18'd20;
        start = 1'b1;
        step(1);
        start = 1'b0;
        cyc = 0;
        while (sb.size() > 14 && cyc < 200) begin
            step(1);
            cyc++;
        end
        chk("midrst_reached", 64'(sb.size() <= 14), 64'd1);
        reset = 1'b1;
        step(1);
        sb.delete();
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_iv", 64'(input_valid), 64'd0);
        chk("midrst_rd_en", 64'(mem_rd_en), 64'd0);
        reset = 1'b0;
        step(20);
        chk("midrst_stay_idle", 64'(busy), 64'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
        $finish;
    end

endmodule
